// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the inter-stage pipeline registers:
//                occupancy state encoding, the control NOP encoding and the
//                default payload widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 16;

    // Control bits of a bubble: every control signal deasserted.
    localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] n;
        case (s)
            ST_ONE:  n = 2'd1;
            ST_TWO:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One storage slot of a pipeline stage: valid flag, control
//                payload and data payload with load enable and clear.
//                Clear dominates load; clear zeroes valid and control but
//                keeps the data payload.
//  Ports       : clk_i, rst_ni   - clock, async active-low reset
//                load_i, clear_i - capture inputs / kill the entry
//                valid_i, ctrl_i, data_i - entry to capture
//                valid_o, ctrl_o, data_o - held entry
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_W'(CTRL_NOP);
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_W'(CTRL_NOP);
        end else if (load_i) begin
            valid_q <= valid_i;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Inter-stage pipeline register with valid/ready handshake,
//                two-entry skid buffer and synchronous flush. Control output
//                is forced to NOP whenever no valid entry is presented.
//  Ports       : clk_i, rst_ni            - clock, async active-low reset
//                in_valid_i/in_ready_o    - upstream handshake
//                in_ctrl_i, in_data_i     - upstream payload
//                flush_i                  - kill all held entries
//                out_valid_o/out_ready_i  - downstream handshake
//                out_ctrl_o, out_data_o   - head entry payload
//                occupancy_o              - entries held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    state_e            state_q, state_d;

    logic              main_load, main_clear;
    logic              skid_load, skid_clear;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    logic              main_valid_q, skid_valid_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    logic              in_fire, out_fire;

    // Ready depends only on registered state, so no combinational path
    // from the downstream handshake or flush reaches the upstream stage.
    assign in_ready_o = (state_q != ST_TWO);
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = main_valid_q & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_load   = 1'b0;
        main_clear  = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        main_ctrl_d = in_ctrl_i;
        main_data_d = in_data_i;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end else if (out_fire) begin
                    main_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Skid entry advances to the head once the head leaves.
                if (out_fire) begin
                    main_load   = 1'b1;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_clear  = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
                state_d    = ST_EMPTY;
            end
        endcase

        // Flush overrides everything, including an entry accepted this cycle.
        if (flush_i) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (main_load),
        .clear_i (main_clear),
        .valid_i (1'b1),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid_q),
        .ctrl_o  (main_ctrl_q),
        .data_o  (main_data_q)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .valid_i (1'b1),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (skid_valid_q),
        .ctrl_o  (skid_ctrl_q),
        .data_o  (skid_data_q)
    );

    // Skid validity is implied by the state; kept in the slot for symmetry.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid_q;

    assign out_valid_o = main_valid_q;
    assign out_ctrl_o  = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign out_data_o  = main_data_q;
    assign occupancy_o = occ_of(state_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. A queue model
//                predicts outputs every cycle; directed scenarios add
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] c;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];

    pipe_stage_reg #(
        .DATA_W (32),
        .CTRL_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (out_ctrl),
        .out_data_o  (out_data),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two entries; acceptance only while not full.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            automatic bit acc = in_valid && (q.size() < 2);
            automatic bit dlv = (q.size() > 0) && out_ready;
            if (dlv) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back('{c: in_ctrl, d: in_data});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("m_in_ready",  64'(in_ready),  64'(q.size() < 2));
            chk("m_occupancy", 64'(occupancy), 64'(q.size()));
            chk("m_out_ctrl",  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
            if (q.size() > 0) chk("m_out_data", 64'(out_data), 64'(q[0].d));
        end
    end

    // Drive one cycle of inputs, return #1 after the capturing edge.
    task automatic step(input logic v, input logic [15:0] c, input logic [31:0] d,
                        input logic r, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string nm, input logic v, input logic [15:0] c,
                        input logic [31:0] d, input logic rdy, input logic [1:0] occ);
        chk({nm, "_valid"}, 64'(out_valid), 64'(v));
        chk({nm, "_ctrl"},  64'(out_ctrl),  64'(c));
        if (v) chk({nm, "_data"}, 64'(out_data), 64'(d));
        chk({nm, "_ready"}, 64'(in_ready),  64'(rdy));
        chk({nm, "_occ"},   64'(occupancy), 64'(occ));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("reset", 1'b0, 16'h0, 32'h0, 1'b1, 2'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: one entry per cycle, head lags input by one cycle.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 32'(i), 1'b1, 1'b0);
            look("stream", 1'b1, 16'h0100 + 16'(i), 32'(i), 1'b1, 2'd1);
        end
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        look("drain", 1'b0, 16'h0, 32'h0, 1'b1, 2'd0);

        // Backpressure: second accept fills skid, then ready drops.
        step(1'b1, 16'h0A0A, 32'd10, 1'b0, 1'b0);
        look("bp1", 1'b1, 16'h0A0A, 32'd10, 1'b1, 2'd1);
        step(1'b1, 16'h0B0B, 32'd11, 1'b0, 1'b0);
        look("bp2", 1'b1, 16'h0A0A, 32'd10, 1'b0, 2'd2);
        step(1'b1, 16'h0C0C, 32'd12, 1'b0, 1'b0);
        look("bp3", 1'b1, 16'h0A0A, 32'd10, 1'b0, 2'd2);
        step(1'b1, 16'h0C0C, 32'd12, 1'b1, 1'b0);
        look("bp4", 1'b1, 16'h0B0B, 32'd11, 1'b1, 2'd1);
        step(1'b1, 16'h0C0C, 32'd12, 1'b1, 1'b0);
        look("bp5", 1'b1, 16'h0C0C, 32'd12, 1'b1, 2'd1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        look("bp6", 1'b0, 16'h0, 32'h0, 1'b1, 2'd0);

        // Flush while full with a new entry offered.
        step(1'b1, 16'h1414, 32'd20, 1'b0, 1'b0);
        step(1'b1, 16'h1515, 32'd21, 1'b0, 1'b0);
        look("fl_full", 1'b1, 16'h1414, 32'd20, 1'b0, 2'd2);
        step(1'b1, 16'h1616, 32'd22, 1'b0, 1'b1);
        look("fl_after", 1'b0, 16'h0, 32'h0, 1'b1, 2'd0);
        step(1'b1, 16'h1717, 32'd23, 1'b1, 1'b0);
        look("fl_next", 1'b1, 16'h1717, 32'd23, 1'b1, 2'd1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // Bubble in the middle of a stream with all control bits set.
        step(1'b1, 16'h1E1E, 32'd30, 1'b1, 1'b0);
        look("bub0", 1'b1, 16'h1E1E, 32'd30, 1'b1, 2'd1);
        step(1'b0, 16'hFFFF, 32'd99, 1'b1, 1'b0);
        look("bub1", 1'b0, 16'h0000, 32'h0, 1'b1, 2'd0);
        step(1'b1, 16'h1F1F, 32'd31, 1'b1, 1'b0);
        look("bub2", 1'b1, 16'h1F1F, 32'd31, 1'b1, 2'd1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // Simultaneous accept and deliver, then the same with flush.
        step(1'b1, 16'h2828, 32'd40, 1'b0, 1'b0);
        step(1'b1, 16'h2929, 32'd41, 1'b1, 1'b0);
        look("sim1", 1'b1, 16'h2929, 32'd41, 1'b1, 2'd1);
        step(1'b1, 16'h2A2A, 32'd42, 1'b1, 1'b1);
        look("sim2", 1'b0, 16'h0, 32'h0, 1'b1, 2'd0);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 32'd1000 + 32'(i),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset pulse while full, between clock edges.
        step(1'b1, 16'h3232, 32'd50, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 32'd51, 1'b0, 1'b0);
        step(1'b1, 16'h3434, 32'd52, 1'b0, 1'b0);
        look("prerst", 1'b1, occupancy == 2'd2 ? out_ctrl : 16'h0, out_data, 1'b0, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        look("asyncrst", 1'b0, 16'h0, 32'h0, 1'b1, 2'd0);
        chk("asyncrst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h3C3C, 32'd60, 1'b1, 1'b0);
        look("postrst", 1'b1, 16'h3C3C, 32'd60, 1'b1, 2'd1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the processor datapath, successor to the fixed-field stage registers. It carries an opaque control vector and an opaque data vector between two pipeline stages with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. Control bits are forced to the NOP encoding (all zero) whenever the stage holds no valid instruction, so downstream stages see a bubble during stalls and flushes.

## Interface
- DATA_W, 32: width of the datapath payload (operands, immediates, PC+4, ...); never cleared by flush.
- CTRL_W, 16: width of the control payload (RegWrite, MemWrite, Branch, ...); all-zero is the NOP encoding.

- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- InValid  in  1  upstream stage presents an instruction.
- InReady  out  1  register can accept; a function of state only (registered).
- InCtrl  in  CTRL_W  control payload from upstream.
- InData  in  DATA_W  data payload from upstream.
- Flush  in  1  synchronous kill of all held entries (branch/jump redirect).
- OutValid  out  1  head entry valid.
- OutReady  in  1  downstream stage accepts the head entry.
- OutCtrl  out  CTRL_W  head control; zero whenever OutValid=0.
- OutData  out  DATA_W  head data; don't-care when OutValid=0.
- Occupancy  out  2  entries held (0, 1 or 2).

## Operation
- in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- Two slots: main (drives outputs) and skid. States EMPTY, ONE (main full), TWO (main and skid full).
- EMPTY: in_fire -> main<=In, ONE.
- ONE: in_fire & out_fire -> main<=In, stay ONE; in_fire only -> skid<=In, TWO; out_fire only -> EMPTY.
- TWO: InReady=0; out_fire -> main<=skid, ONE; otherwise hold.
- InReady = (state != TWO).
- Flush: next state EMPTY regardless of in_fire/out_fire in the same cycle; the entry accepted in that cycle is discarded. out_fire in the flush cycle still counts as delivered downstream.
- OutCtrl = main_ctrl gated by OutValid (combinational AND). OutData = main_data ungated.
- Occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Order is strictly FIFO; no entry is duplicated or dropped except by Flush.

## Timing
- Reset (Rst_n low, asynchronous): state EMPTY, main and skid registers zero; OutValid=0, OutCtrl=0, OutData=0, InReady=1, Occupancy=0. Outputs stay at these values until the first rising edge after deassertion.
- Latency: 1 cycle from in_fire to OutValid in EMPTY.
- Throughput: 1 entry/cycle when OutReady is held high.
- InReady has no combinational path from OutReady, InValid or Flush.
- OutReady dropping for N cycles: at most one extra entry is absorbed into skid, then InReady=0 from the following cycle.
- Flush and Rst_n low together: reset wins.
- After Flush, InReady=1 and OutValid=0 on the next cycle.

## Structure
- Shared package pipe_pkg: state enum (EMPTY, ONE, TWO), the CTRL_NOP constant (all-zero) and the default DATA_W/CTRL_W values, used by all stage instances.
- Sub-module pipe_slot (valid + ctrl + data register with load enable and clear) instantiated twice for main and skid. No other hierarchy.

## Test plan
- Reset mid-stream: hold state TWO, pulse Rst_n low between edges -> OutValid=0, OutCtrl=0, OutData=0 and InReady=1 immediately, without waiting for a clock edge.
- Streaming: InValid=1, OutReady=1, InData=1,2,3... -> OutData=1,2,3... each one cycle later; InReady stays 1; Occupancy stays 1.
- Backpressure: stream with OutReady=0 for 3 cycles -> Occupancy goes 1 then 2, InReady=0 from the cycle after the second accept, the head value is held, no loss after OutReady returns.
- Flush in TWO with InValid=1 -> next cycle OutValid=0, OutCtrl=0, Occupancy=0, InReady=1; the flushed entries never appear on the outputs.
- Bubble: InValid=0 for one cycle within a stream, InCtrl=16'hFFFF -> OutValid=0 and OutCtrl=16'h0000 for one cycle, then the stream resumes in order.
- Simultaneous events: in ONE with in_fire and out_fire together -> Occupancy stays 1 and the new entry is at the head the next cycle; the same with Flush asserted -> Occupancy 0.
